mrf_rx_decoder: RTL and testbench
=================================

Name: mrf_rx_decoder

Overview:
Receive-side MRF link decoder that consumes the 16-bit/2-K-flag word stream out of the GTP receiver (gtpwizard / gtp_model rx path). It is the receive counterpart of the transmit frame generator.
- Finds K28.5 commas and corrects byte misalignment.
- Qualifies the link with a lock state machine.
- Extracts event codes (low byte) and distributed-bus bytes (high byte), and counts link errors.

Parameters:
COMMA, 8'hBC, K character value treated as comma (K28.5)
SYNC_COMMAS, 4, consecutive correctly placed commas required to declare lock
COMMA_TIMEOUT, 1024, words without a comma before lock is dropped
ERR_THRESH, 4, leaky error level that drops lock
LEAK_PERIOD, 256, clean words needed to decrement the error level by 1

Ports:
aclk  in  1  receive word clock (GTP rx user clock)
aresetn  in  1  asynchronous active-low reset
rx_ready  in  1  GTP rx_reset_done; low = stream invalid
rx_data  in  16  received word, byte0 = [7:0]
rx_is_k  in  2  per-byte K flag, bit0 -> byte0
link_up  out  1  high while in LOCKED
swapped  out  1  1 = byte alignment correction active
event_valid  out  1  single-cycle strobe, event_code valid
event_code  out  8  received event code
dbus  out  8  last received distributed-bus byte
err_total  out  16  saturating count of link errors since reset

Behaviour:
- Reset (aresetn low, asynchronous) clears all state: state=LOS, all outputs 0, internal prev byte/counters 0.
- rx_ready low: synchronously forces state LOS next cycle; clears swapped, link_up and event_valid; holds dbus and err_total.
- Alignment stage (1 register), fed by the current word and the previous word's byte1 (prev_hi):
  - swapped=0: aligned word = rx_data, aligned K = rx_is_k.
  - swapped=1: aligned word = {rx_data[7:0], prev_hi}; K flags are rearranged the same way.
  - prev_hi is captured every cycle regardless of state.
- comma_ok: aligned byte0 == COMMA with aligned K bit0 set.
- Error word: any K byte that is not a valid comma in byte0, or a comma in byte1.
- States, evaluated on aligned data:
  - LOS: go to HUNT when rx_ready is high.
  - HUNT: watch raw rx_data.
    - Comma in raw byte0 -> swapped<=0, go to SYNC.
    - Comma only in raw byte1 -> swapped<=1, go to SYNC.
    - A comma in both bytes is treated as byte0.
  - SYNC: sync_cnt counts comma_ok words.
    - An error word returns to HUNT and clears sync_cnt.
    - sync_cnt reaching SYNC_COMMAS -> LOCKED; link_up=1 from the next cycle.
    - No comma for COMMA_TIMEOUT words -> HUNT.
  - LOCKED:
    - Each error word: err_level+1 and err_total+1 (err_total saturates at 16'hFFFF).
    - Each LEAK_PERIOD consecutive error-free words: err_level-1, floor 0.
    - err_level == ERR_THRESH, or COMMA_TIMEOUT words without comma_ok -> HUNT. On this exit err_level clears and link_up drops next cycle.
- err_total also increments on error words seen in SYNC.
- Outputs (LOCKED only):
  - event_valid=1 and event_code=aligned byte0 when aligned byte0 is not K and != 8'h00.
  - dbus updates to aligned byte1 when aligned byte1 is not K.
  - Latency: rx_data at cycle N -> event_valid/dbus at cycle N+2 (alignment register + output register).
- Simultaneous events: an error word and an elapsing leak period in the same cycle -> the increment wins, and the leak counter restarts.
- Timeout counter is cleared on every comma_ok word and on every state entry.
- Reset mid-stream, at any cycle, gives immediate reset values; recovery requires a full HUNT->SYNC->LOCKED sequence.

Test Plan:
- Stream of 0x00BC (K on bit0) x4, then 0x5A12 (no K) -> link_up=1 after the 4th comma + 2 cycles; then event_valid with code 0x12, dbus 0x5A, swapped=0.
- Same stream shifted by a byte, e.g. 0xBC00 (K bit1) then 0x125A... -> swapped=1; event_code 0x12 and dbus 0x5A are recovered correctly.
- LOCKED, inject 4 words 0x00F7 with K bit0 -> err_total=4, link_up falls on the 4th error + 2 cycles, state HUNT.
- LOCKED, 3 error words, 256 clean words, 1 error -> err_level=3, link stays up, err_total=4.
- LOCKED, 1024 non-comma data words -> link_up drops; no event_valid emitted afterwards until relock.
- Deassert aresetn asynchronously mid-event, and separately drop rx_ready for 1 cycle -> all outputs 0 immediately (aresetn) / LOS next cycle (rx_ready); relock after 4 commas.

Source files
------------

// File: rtl/mrf_rx_decoder.sv
`timescale 1ns/1ps
// MRF receive decoder: K28.5 comma alignment, lock qualification, event code and
// distributed-bus extraction, plus leaky link-error accounting on the GTP rx stream.
module mrf_rx_decoder #(
  parameter logic [7:0] COMMA         = 8'hBC,
  parameter int         SYNC_COMMAS   = 4,
  parameter int         COMMA_TIMEOUT = 1024,
  parameter int         ERR_THRESH    = 4,
  parameter int         LEAK_PERIOD   = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        rx_ready,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_is_k,
  output logic        link_up,
  output logic        swapped,
  output logic        event_valid,
  output logic [7:0]  event_code,
  output logic [7:0]  dbus,
  output logic [15:0] err_total
);

  localparam int SYNC_W = $clog2(SYNC_COMMAS + 1);
  localparam int TO_W   = $clog2(COMMA_TIMEOUT + 1);
  localparam int LVL_W  = $clog2(ERR_THRESH + 1);
  localparam int LEAK_W = $clog2(LEAK_PERIOD + 1);

  localparam logic [SYNC_W-1:0] SYNC_ZERO = {SYNC_W{1'b0}};
  localparam logic [SYNC_W-1:0] SYNC_ONE  = SYNC_W'(1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COMMAS - 1);
  localparam logic [TO_W-1:0]   TO_ZERO   = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(COMMA_TIMEOUT - 1);
  localparam logic [LVL_W-1:0]  LVL_ZERO  = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(ERR_THRESH - 1);
  localparam logic [LEAK_W-1:0] LEAK_ZERO = {LEAK_W{1'b0}};
  localparam logic [LEAK_W-1:0] LEAK_ONE  = LEAK_W'(1);
  localparam logic [LEAK_W-1:0] LEAK_LAST = LEAK_W'(LEAK_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_LOS    = 2'd0,
    ST_HUNT   = 2'd1,
    ST_SYNC   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value != 16'hFFFF) begin
      sat_inc16 = value + 16'd1;
    end else begin
      sat_inc16 = value;
    end
  endfunction

  state_t            state_r;
  logic              swapped_r;
  logic              link_up_r;
  logic              event_valid_r;
  logic [7:0]        event_code_r;
  logic [7:0]        dbus_r;
  logic [15:0]       err_total_r;
  logic [SYNC_W-1:0] sync_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [LVL_W-1:0]  err_lvl_r;
  logic [LEAK_W-1:0] leak_cnt_r;
  logic [7:0]        prev_hi_r;
  logic              prev_k_hi_r;
  logic [15:0]       al_data_r;
  logic [1:0]        al_k_r;

  logic              raw_c0_s;
  logic              raw_c1_s;
  logic              swap_sel_s;
  logic [15:0]       al_data_s;
  logic [1:0]        al_k_s;
  logic              comma_ok_s;
  logic              err_word_s;
  logic              to_expired_s;
  logic              lock_lost_s;
  logic              ev_hit_s;

  // Alignment mux; while hunting the swap decision is applied to the detecting word itself
  always_comb begin
    raw_c0_s = rx_is_k[0] && (rx_data[7:0] == COMMA);
    raw_c1_s = rx_is_k[1] && (rx_data[15:8] == COMMA);
    if ((state_r == ST_HUNT) && raw_c0_s) begin
      swap_sel_s = 1'b0;
    end else if ((state_r == ST_HUNT) && raw_c1_s) begin
      swap_sel_s = 1'b1;
    end else begin
      swap_sel_s = swapped_r;
    end
    if (swap_sel_s) begin
      al_data_s = {rx_data[7:0], prev_hi_r};
      al_k_s    = {rx_is_k[0], prev_k_hi_r};
    end else begin
      al_data_s = rx_data;
      al_k_s    = rx_is_k;
    end
  end

  // Classification of the registered aligned word
  always_comb begin
    comma_ok_s   = al_k_r[0] && (al_data_r[7:0] == COMMA);
    err_word_s   = (al_k_r[0] && !comma_ok_s) || al_k_r[1];
    to_expired_s = !comma_ok_s && (to_cnt_r == TO_LAST);
    lock_lost_s  = (err_word_s && (err_lvl_r == LVL_LAST)) || to_expired_s;
    ev_hit_s     = !al_k_r[0] && (al_data_r[7:0] != 8'h00);
  end

  // Alignment register and previous high byte history
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_hi_r   <= 8'h00;
      prev_k_hi_r <= 1'b0;
      al_data_r   <= 16'h0000;
      al_k_r      <= 2'b00;
    end else begin
      prev_hi_r   <= rx_data[15:8];
      prev_k_hi_r <= rx_is_k[1];
      al_data_r   <= al_data_s;
      al_k_r      <= al_k_s;
    end
  end

  // Link state machine with registered outputs and error accounting
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r       <= ST_LOS;
      swapped_r     <= 1'b0;
      link_up_r     <= 1'b0;
      event_valid_r <= 1'b0;
      event_code_r  <= 8'h00;
      dbus_r        <= 8'h00;
      err_total_r   <= 16'h0000;
      sync_cnt_r    <= SYNC_ZERO;
      to_cnt_r      <= TO_ZERO;
      err_lvl_r     <= LVL_ZERO;
      leak_cnt_r    <= LEAK_ZERO;
    end else if (!rx_ready) begin
      state_r       <= ST_LOS;
      swapped_r     <= 1'b0;
      link_up_r     <= 1'b0;
      event_valid_r <= 1'b0;
      sync_cnt_r    <= SYNC_ZERO;
      to_cnt_r      <= TO_ZERO;
      err_lvl_r     <= LVL_ZERO;
      leak_cnt_r    <= LEAK_ZERO;
    end else begin
      event_valid_r <= 1'b0;
      case (state_r)
        ST_LOS: begin
          state_r   <= ST_HUNT;
          link_up_r <= 1'b0;
          to_cnt_r  <= TO_ZERO;
        end
        ST_HUNT: begin
          link_up_r <= 1'b0;
          if (raw_c0_s) begin
            swapped_r  <= 1'b0;
            state_r    <= ST_SYNC;
            sync_cnt_r <= SYNC_ZERO;
            to_cnt_r   <= TO_ZERO;
          end else if (raw_c1_s) begin
            swapped_r  <= 1'b1;
            state_r    <= ST_SYNC;
            sync_cnt_r <= SYNC_ZERO;
            to_cnt_r   <= TO_ZERO;
          end else begin
            state_r <= ST_HUNT;
          end
        end
        ST_SYNC: begin
          if (err_word_s) begin
            err_total_r <= sat_inc16(err_total_r);
            state_r     <= ST_HUNT;
            sync_cnt_r  <= SYNC_ZERO;
            to_cnt_r    <= TO_ZERO;
          end else if (comma_ok_s) begin
            to_cnt_r <= TO_ZERO;
            if (sync_cnt_r == SYNC_LAST) begin
              state_r    <= ST_LOCKED;
              link_up_r  <= 1'b1;
              sync_cnt_r <= SYNC_ZERO;
              err_lvl_r  <= LVL_ZERO;
              leak_cnt_r <= LEAK_ZERO;
            end else begin
              sync_cnt_r <= sync_cnt_r + SYNC_ONE;
            end
          end else if (to_cnt_r == TO_LAST) begin
            state_r    <= ST_HUNT;
            sync_cnt_r <= SYNC_ZERO;
            to_cnt_r   <= TO_ZERO;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end
        ST_LOCKED: begin
          if (ev_hit_s) begin
            event_valid_r <= 1'b1;
            event_code_r  <= al_data_r[7:0];
          end else begin
            event_code_r <= event_code_r;
          end
          if (!al_k_r[1]) begin
            dbus_r <= al_data_r[15:8];
          end else begin
            dbus_r <= dbus_r;
          end
          if (err_word_s) begin
            err_total_r <= sat_inc16(err_total_r);
          end else begin
            err_total_r <= err_total_r;
          end
          if (lock_lost_s) begin
            state_r    <= ST_HUNT;
            link_up_r  <= 1'b0;
            err_lvl_r  <= LVL_ZERO;
            leak_cnt_r <= LEAK_ZERO;
            to_cnt_r   <= TO_ZERO;
          end else begin
            to_cnt_r <= comma_ok_s ? TO_ZERO : (to_cnt_r + TO_ONE);
            // An error word always restarts the leak window, so it wins over a decrement
            if (err_word_s) begin
              err_lvl_r  <= err_lvl_r + LVL_ONE;
              leak_cnt_r <= LEAK_ZERO;
            end else if (leak_cnt_r == LEAK_LAST) begin
              leak_cnt_r <= LEAK_ZERO;
              if (err_lvl_r != LVL_ZERO) begin
                err_lvl_r <= err_lvl_r - LVL_ONE;
              end else begin
                err_lvl_r <= err_lvl_r;
              end
            end else begin
              leak_cnt_r <= leak_cnt_r + LEAK_ONE;
            end
          end
        end
        default: begin
          state_r   <= ST_LOS;
          link_up_r <= 1'b0;
        end
      endcase
    end
  end

  assign link_up     = link_up_r;
  assign swapped     = swapped_r;
  assign event_valid = event_valid_r;
  assign event_code  = event_code_r;
  assign dbus        = dbus_r;
  assign err_total   = err_total_r;

endmodule

// File: tb/tb_mrf_rx_decoder.sv
`timescale 1ns/1ps
// Directed + randomised bench for mrf_rx_decoder; outputs are compared every cycle
// against a byte-stream reference model of the link rules.
module tb_mrf_rx_decoder;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic [1:0]  rx_is_k;
  logic        link_up;
  logic        swapped;
  logic        event_valid;
  logic [7:0]  event_code;
  logic [7:0]  dbus;
  logic [15:0] err_total;

  always #5 aclk = ~aclk;

  mrf_rx_decoder dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_is_k     (rx_is_k),
    .link_up     (link_up),
    .swapped     (swapped),
    .event_valid (event_valid),
    .event_code  (event_code),
    .dbus        (dbus),
    .err_total   (err_total)
  );

  localparam int MD_LOS = 0, MD_HUNT = 1, MD_SYNC = 2, MD_LOCKED = 3;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model: byte history since reset, link mode, counters and expected outputs
  logic [8:0]  m_hist[$];
  logic [8:0]  byte_q[$];
  int          m_mode, m_sync, m_to, m_lvl, m_leak;
  bit          m_swap;
  logic [7:0]  p_b0, p_b1;
  bit          p_k0, p_k1;
  logic        e_link, e_ev;
  logic [7:0]  e_code, e_dbus;
  logic [15:0] e_tot;
  bit          seen12, seen5a;
  int          ev_count;

  function automatic void model_reset();
    m_hist.delete();
    m_hist.push_back(9'h000);
    m_mode = MD_LOS; m_sync = 0; m_to = 0; m_lvl = 0; m_leak = 0; m_swap = 1'b0;
    p_b0 = 8'h00; p_b1 = 8'h00; p_k0 = 1'b0; p_k1 = 1'b0;
    e_link = 1'b0; e_ev = 1'b0; e_code = 8'h00; e_dbus = 8'h00; e_tot = 16'h0000;
  endfunction

  function automatic void model_step(input logic rdy, input logic [15:0] w, input logic [1:0] k);
    bit comma, err, c0, c1;
    int off, n;
    logic [8:0] b0, b1;
    comma = p_k0 && (p_b0 == 8'hBC);
    err   = (p_k0 && !comma) || p_k1;
    c0    = k[0] && (w[7:0] == 8'hBC);
    c1    = k[1] && (w[15:8] == 8'hBC);
    off   = m_swap ? 1 : 0;
    if (m_mode == MD_HUNT && c0) off = 0;
    else if (m_mode == MD_HUNT && c1) off = 1;
    m_hist.push_back({k[0], w[7:0]});
    m_hist.push_back({k[1], w[15:8]});
    while (m_hist.size() > 3) m_hist.delete(0);
    n  = m_hist.size();
    b0 = m_hist[n-2-off];
    b1 = m_hist[n-1-off];
    e_ev = 1'b0;
    if (!rdy) begin
      m_mode = MD_LOS; m_swap = 1'b0; m_sync = 0; m_to = 0; m_lvl = 0; m_leak = 0;
    end else begin
      case (m_mode)
        MD_LOS: m_mode = MD_HUNT;
        MD_HUNT: begin
          if (c0 || c1) begin
            m_swap = !c0;
            m_mode = MD_SYNC; m_sync = 0; m_to = 0;
          end
        end
        MD_SYNC: begin
          if (err) begin
            if (e_tot != 16'hFFFF) e_tot++;
            m_mode = MD_HUNT; m_sync = 0; m_to = 0;
          end else if (comma) begin
            m_to = 0;
            m_sync++;
            if (m_sync == 4) begin
              m_mode = MD_LOCKED; m_sync = 0; m_lvl = 0; m_leak = 0;
            end
          end else begin
            m_to++;
            if (m_to == 1024) begin
              m_mode = MD_HUNT; m_to = 0; m_sync = 0;
            end
          end
        end
        MD_LOCKED: begin
          if (!p_k0 && p_b0 != 8'h00) begin
            e_ev = 1'b1; e_code = p_b0;
          end
          if (!p_k1) e_dbus = p_b1;
          if (err) begin
            if (e_tot != 16'hFFFF) e_tot++;
            m_lvl++; m_leak = 0;
          end else begin
            m_leak++;
            if (m_leak == 256) begin
              m_leak = 0;
              if (m_lvl > 0) m_lvl--;
            end
          end
          if (comma) m_to = 0;
          else m_to++;
          if (m_lvl == 4 || m_to == 1024) begin
            m_mode = MD_HUNT; m_lvl = 0; m_leak = 0; m_to = 0;
          end
        end
        default: m_mode = MD_LOS;
      endcase
    end
    {p_k0, p_b0} = b0;
    {p_k1, p_b1} = b1;
    e_link = (m_mode == MD_LOCKED);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("link_up", 16'(link_up), 16'(e_link));
    chk("swapped", 16'(swapped), 16'(m_swap));
    chk("event_valid", 16'(event_valid), 16'(e_ev));
    chk("event_code", 16'(event_code), 16'(e_code));
    chk("dbus", 16'(dbus), 16'(e_dbus));
    chk("err_total", err_total, e_tot);
  endtask

  task automatic step(input logic [15:0] w, input logic [1:0] k, input logic rdy);
    rx_data = w; rx_is_k = k; rx_ready = rdy;
    @(posedge aclk);
    model_step(rdy, w, k);
    #1;
    check_all();
    if (event_valid && event_code == 8'h12) seen12 = 1'b1;
    if (dbus == 8'h5A) seen5a = 1'b1;
    if (event_valid) ev_count++;
  endtask

  function automatic logic [15:0] rnd_data();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 7) == 0) v[7:0] = 8'h00;
    return v;
  endfunction

  task automatic flush(input bit shift);
    logic [8:0] lo, hi;
    if (shift) byte_q.push_front(9'h000);
    if (byte_q.size() % 2 != 0) byte_q.push_back(9'h000);
    while (byte_q.size() > 0) begin
      lo = byte_q.pop_front();
      hi = byte_q.pop_front();
      step({hi[7:0], lo[7:0]}, {hi[8], lo[8]}, 1'b1);
    end
  endtask

  task automatic lock_plain();
    repeat (4) step(16'h00BC, 2'b01, 1'b1);
    step(16'h5A12, 2'b00, 1'b1);
    step(16'h0000, 2'b00, 1'b1);
  endtask

  initial begin
    aresetn = 1'b0; rx_ready = 1'b0; rx_data = 16'h0000; rx_is_k = 2'b00;
    seen12 = 1'b0; seen5a = 1'b0; ev_count = 0;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    check_all();
    chk("reset_link", 16'(link_up), 16'd0);
    #3 aresetn = 1'b1;

    // plain lock: link_up two cycles after the 4th comma, then event 0x12 / dbus 0x5A
    repeat (3) step(16'h0000, 2'b00, 1'b1);
    repeat (4) step(16'h00BC, 2'b01, 1'b1);
    chk("lock_pending", 16'(link_up), 16'd0);
    step(16'h5A12, 2'b00, 1'b1);
    chk("lock_up", 16'(link_up), 16'd1);
    chk("lock_unswapped", 16'(swapped), 16'd0);
    step(16'h0000, 2'b00, 1'b1);
    chk("ev_strobe", 16'(event_valid), 16'd1);
    chk("ev_code", 16'(event_code), 16'h12);
    chk("ev_dbus", 16'(dbus), 16'h5A);

    // random locked traffic with periodic commas
    for (int i = 0; i < 200; i++) begin
      if (i % 20 == 19) step(16'h00BC, 2'b01, 1'b1);
      else step(rnd_data(), 2'b00, 1'b1);
    end

    // leaky level: 3 errors, 256 clean, 1 error leaves level 3 and the link up
    repeat (3) step(16'h00F7, 2'b01, 1'b1);
    for (int i = 0; i < 256; i++) begin
      if (i % 16 == 15) step(16'h00BC, 2'b01, 1'b1);
      else step(rnd_data(), 2'b00, 1'b1);
    end
    step(16'h00F7, 2'b01, 1'b1);
    repeat (4) step(16'h1234, 2'b00, 1'b1);
    chk("leak_link", 16'(link_up), 16'd1);
    chk("leak_total", err_total, 16'd4);
    step(16'h00F7, 2'b01, 1'b1);
    chk("leak_hold", 16'(link_up), 16'd1);
    step(16'h0000, 2'b00, 1'b1);
    chk("leak_drop", 16'(link_up), 16'd0);

    // relock, then 4 consecutive errors drop the link
    lock_plain();
    chk("relock1", 16'(link_up), 16'd1);
    repeat (4) step(16'h00F7, 2'b01, 1'b1);
    chk("err4_hold", 16'(link_up), 16'd1);
    step(16'h0000, 2'b00, 1'b1);
    chk("err4_drop", 16'(link_up), 16'd0);
    chk("err4_total", err_total, 16'd9);

    // byte-shifted stream locks with swap and recovers 0x12 / 0x5A
    repeat (2) step(16'h0000, 2'b00, 1'b1);
    seen12 = 1'b0; seen5a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      byte_q.push_back({1'b1, 8'hBC}); byte_q.push_back(9'h000);
    end
    byte_q.push_back({1'b0, 8'h12}); byte_q.push_back({1'b0, 8'h5A});
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) begin
        byte_q.push_back({1'b1, 8'hBC}); byte_q.push_back(9'h000);
      end else begin
        byte_q.push_back({1'b0, 8'($urandom)});
      end
    end
    flush(1'b1);
    chk("swap_flag", 16'(swapped), 16'd1);
    chk("swap_link", 16'(link_up), 16'd1);
    chk("swap_ev12", 16'(seen12), 16'd1);
    chk("swap_db5a", 16'(seen5a), 16'd1);

    // comma starvation drops the link; no events afterwards
    repeat (1100) step(16'(($urandom & 32'h0000_FF00) | 32'h0000_0033), 2'b00, 1'b1);
    chk("to_drop", 16'(link_up), 16'd0);
    ev_count = 0;
    repeat (20) step(16'h4321, 2'b00, 1'b1);
    chk("to_no_events", 16'(ev_count), 16'd0);

    // asynchronous reset in the middle of an event
    lock_plain();
    chk("pre_reset_ev", 16'(event_valid), 16'd1);
    #3 aresetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_tot", err_total, 16'd0);
    chk("rst_dbus", 16'(dbus), 16'd0);
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    step(16'h0000, 2'b00, 1'b1);
    lock_plain();
    chk("rst_relock", 16'(link_up), 16'd1);

    // one-cycle rx_ready drop forces LOS, then full relock
    step(16'h3344, 2'b00, 1'b0);
    chk("rdy_link", 16'(link_up), 16'd0);
    chk("rdy_ev", 16'(event_valid), 16'd0);
    step(16'h0000, 2'b00, 1'b1);
    lock_plain();
    chk("rdy_relock", 16'(link_up), 16'd1);

    // randomised mix of data, commas and stray K bytes
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) step(16'($urandom), 2'($urandom_range(1, 3)), 1'b1);
      else if (r < 6) step(16'hBC00, 2'b10, 1'b1);
      else if (r < 16) step(16'h00BC, 2'b01, 1'b1);
      else step(rnd_data(), 2'b00, 1'b1);
    end

    if (n_fail != 0) $display("%0d comparisons reported errors", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
